// File: rtl/logic_response_checker_if.sv
// ----------------------------------------------------------------------------
// logic_response_checker_if
// Sample handshake between a gate-under-test wrapper (master) and the
// response checker (slave).
//   in_valid    master -> slave  a sample is present on y_expected/y_actual
//   in_ready    slave  -> master checker accepts a sample this cycle
//   y_expected  master -> slave  reference output value
//   y_actual    master -> slave  output value from the gate under test
// ----------------------------------------------------------------------------
interface logic_response_checker_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y_expected;
   logic [WIDTH-1:0] y_actual;

   modport master (output in_valid, output y_expected, output y_actual, input in_ready);
   modport slave  (input in_valid, input y_expected, input y_actual, output in_ready);
endinterface

// File: rtl/logic_response_checker.sv
// ----------------------------------------------------------------------------
// logic_response_checker
// Accepts (expected, actual) sample pairs one at a time, counts matches and
// mismatches, latches the first mismatch and reports a pass/fail verdict once
// NUM_VECTORS samples have been accepted.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           begins a run (honoured in IDLE and DONE only)
//   smp             sample handshake (slave side: in_valid, in_ready, y_*)
//   busy            run in progress
//   done            run complete, held until next start or rst
//   pass            valid while done; 1 when no sample mismatched
//   mismatch        one-cycle pulse per failing sample
//   pass_count      samples that matched (saturating)
//   fail_count      samples that mismatched (saturating)
//   first_fail_idx  0-based index of the first mismatching sample
//   first_fail_exp  y_expected of the first mismatch
//   first_fail_act  y_actual of the first mismatch
// ----------------------------------------------------------------------------
module logic_response_checker #(
   parameter int WIDTH       = 1,
   parameter int CNT_W       = 16,
   parameter int NUM_VECTORS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   logic_response_checker_if.slave  smp,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     mismatch,
   output logic [CNT_W-1:0]         pass_count,
   output logic [CNT_W-1:0]         fail_count,
   output logic [CNT_W-1:0]         first_fail_idx,
   output logic [WIDTH-1:0]         first_fail_exp,
   output logic [WIDTH-1:0]         first_fail_act
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] sample_idx;
   logic             fail_seen;
   logic             accept;
   logic             clear;
   logic             is_match;

   assign is_match = (smp.y_expected == smp.y_actual);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake/status decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt    = state;
      smp.in_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      accept       = 1'b0;
      clear        = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            smp.in_ready = 1'b1;
            busy         = 1'b1;
            accept       = smp.in_valid;
            // start is deliberately not looked at here: a run cannot restart.
            if (accept && (sample_idx == LAST_IDX)) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               clear     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // pass only means something while done; hold it low otherwise.
   assign pass = done && (fail_count == '0);

   // Counters, sample index and first-failure capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_count     <= '0;
         fail_count     <= '0;
         sample_idx     <= '0;
         fail_seen      <= 1'b0;
         mismatch       <= 1'b0;
         first_fail_idx <= '0;
         first_fail_exp <= '0;
         first_fail_act <= '0;
      end else begin
         mismatch <= 1'b0;
         if (clear) begin
            pass_count     <= '0;
            fail_count     <= '0;
            sample_idx     <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_act <= '0;
         end else if (accept) begin
            if (sample_idx != CNT_MAX) sample_idx <= sample_idx + 1'b1;
            if (is_match) begin
               if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
            end else begin
               if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
               mismatch <= 1'b1;
               // Only the first mismatch of a run is recorded.
               if (!fail_seen) begin
                  fail_seen      <= 1'b1;
                  first_fail_idx <= sample_idx;
                  first_fail_exp <= smp.y_expected;
                  first_fail_act <= smp.y_actual;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_response_checker.sv
// ----------------------------------------------------------------------------
// tb_logic_response_checker
// Two checker instances: u0 (NUM_VECTORS=2) and u1 (NUM_VECTORS=4). The driver
// pushes hand-computed expected responses into per-instance queues as it
// issues samples; a negedge monitor pops one entry per accepted sample (the
// cycle after the accept) and one verdict entry whenever done rises.
// ----------------------------------------------------------------------------
module tb_logic_response_checker;

   typedef struct {
      logic        mm;
      logic [15:0] pc;
      logic [15:0] fc;
   } acc_t;

   typedef struct {
      logic        ps;
      logic [15:0] idx;
      logic        e;
      logic        a;
   } fin_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;

   logic busy0, done0, pass0, mm0;
   logic [15:0] pc0, fc0, ffi0;
   logic ffe0, ffa0;
   logic busy1, done1, pass1, mm1;
   logic [15:0] pc1, fc1, ffi1;
   logic ffe1, ffa1;

   int total = 0;
   int bad   = 0;

   acc_t aq0[$], aq1[$];
   fin_t fq0[$], fq1[$];

   logic acc_prev0 = 1'b0, acc_prev1 = 1'b0;
   logic done_prev0 = 1'b0, done_prev1 = 1'b0;

   always #5 clk = ~clk;

   logic_response_checker_if #(.WIDTH(1)) sif0 ();
   logic_response_checker_if #(.WIDTH(1)) sif1 ();

   logic_response_checker #(.WIDTH(1), .CNT_W(16), .NUM_VECTORS(2)) u0 (
      .clk(clk), .rst(rst), .start(start0), .smp(sif0.slave),
      .busy(busy0), .done(done0), .pass(pass0), .mismatch(mm0),
      .pass_count(pc0), .fail_count(fc0), .first_fail_idx(ffi0),
      .first_fail_exp(ffe0), .first_fail_act(ffa0)
   );

   logic_response_checker #(.WIDTH(1), .CNT_W(16), .NUM_VECTORS(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .smp(sif1.slave),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1),
      .pass_count(pc1), .fail_count(fc1), .first_fail_idx(ffi1),
      .first_fail_exp(ffe1), .first_fail_act(ffa1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic mon(input int d, input logic acc_prev, input logic mm,
                      input logic [15:0] pc, input logic [15:0] fc,
                      input logic dn, input logic dn_prev, input logic ps,
                      input logic [15:0] ffi, input logic ffe, input logic ffa);
      acc_t ea;
      fin_t ef;
      if (acc_prev) begin
         if ((d == 0 && aq0.size() == 0) || (d == 1 && aq1.size() == 0)) begin
            total++; bad++;
            $display("FAIL u%0d unexpected accept: got accept want none", d);
         end else begin
            ea = (d == 0) ? aq0.pop_front() : aq1.pop_front();
            check($sformatf("u%0d mismatch", d), 32'(mm), 32'(ea.mm));
            check($sformatf("u%0d pass_count", d), 32'(pc), 32'(ea.pc));
            check($sformatf("u%0d fail_count", d), 32'(fc), 32'(ea.fc));
         end
      end else if (mm) begin
         check($sformatf("u%0d mismatch_no_accept", d), 32'(mm), 32'd0);
      end
      if (dn && !dn_prev) begin
         if ((d == 0 && fq0.size() == 0) || (d == 1 && fq1.size() == 0)) begin
            total++; bad++;
            $display("FAIL u%0d unexpected done: got done=1 want no verdict", d);
         end else begin
            ef = (d == 0) ? fq0.pop_front() : fq1.pop_front();
            check($sformatf("u%0d pass", d), 32'(ps), 32'(ef.ps));
            check($sformatf("u%0d first_fail_idx", d), 32'(ffi), 32'(ef.idx));
            check($sformatf("u%0d first_fail_exp", d), 32'(ffe), 32'(ef.e));
            check($sformatf("u%0d first_fail_act", d), 32'(ffa), 32'(ef.a));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, acc_prev0, mm0, pc0, fc0, done0, done_prev0, pass0, ffi0, ffe0, ffa0);
      mon(1, acc_prev1, mm1, pc1, fc1, done1, done_prev1, pass1, ffi1, ffe1, ffa1);
      // Inputs are stable here and will be sampled at the coming edge.
      acc_prev0  <= sif0.in_valid && sif0.in_ready;
      acc_prev1  <= sif1.in_valid && sif1.in_ready;
      done_prev0 <= done0;
      done_prev1 <= done1;
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int d, input logic v, input logic e, input logic a);
      if (d == 0) begin
         sif0.in_valid = v; sif0.y_expected = e; sif0.y_actual = a;
      end else begin
         sif1.in_valid = v; sif1.y_expected = e; sif1.y_actual = a;
      end
   endtask

   task automatic do_start(input int d);
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic push_final(input int d, input logic ps, input logic [15:0] idx,
                             input logic e, input logic a);
      fin_t f;
      f.ps = ps; f.idx = idx; f.e = e; f.a = a;
      if (d == 0) fq0.push_back(f); else fq1.push_back(f);
   endtask

   task automatic send(input int d, input logic e, input logic a,
                       input logic mm, input logic [15:0] pc, input logic [15:0] fc);
      acc_t x;
      int   n;
      logic rdy;
      x.mm = mm; x.pc = pc; x.fc = fc;
      if (d == 0) aq0.push_back(x); else aq1.push_back(x);
      set_in(d, 1'b1, e, a);
      n = 0;
      rdy = (d == 0) ? sif0.in_ready : sif1.in_ready;
      while (!rdy && n < 20) begin
         tick();
         n++;
         rdy = (d == 0) ? sif0.in_ready : sif1.in_ready;
      end
      if (!rdy) begin
         total++; bad++;
         $display("FAIL u%0d ready_timeout: got in_ready=0 want 1", d);
         if (d == 0) void'(aq0.pop_back()); else void'(aq1.pop_back());
      end else begin
         tick();
      end
      set_in(d, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(0, 1'b0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;

      // Reset state.
      check("rst in_ready", 32'(sif0.in_ready), 0);
      check("rst busy", 32'(busy0), 0);
      check("rst done", 32'(done0), 0);
      check("rst pass", 32'(pass0), 0);
      check("rst counts", 32'({pc0, fc0}), 0);
      check("rst first_fail", 32'({ffi0, ffe0, ffa0}), 0);

      // Gapped valid on u1 (NUM_VECTORS=4), samples 1 and 3 fail.
      do_start(1);
      check("u1 start in_ready", 32'(sif1.in_ready), 1);
      push_final(1, 1'b0, 16'd1, 1'b0, 1'b1);
      send(1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
      repeat (3) tick();
      send(1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1);
      repeat (3) tick();
      send(1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);
      check("u1 not done after 3", 32'(done1), 0);
      repeat (3) tick();
      send(1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd2);
      check("u1 done after 4", 32'(done1), 1);

      // NOT-gate pattern on u0: all match.
      do_start(0);
      check("u0 start busy", 32'(busy0), 1);
      push_final(0, 1'b1, 16'd0, 1'b0, 1'b0);
      send(0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
      send(0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0);
      check("u0 done", 32'(done0), 1);
      check("u0 in_ready after done", 32'(sif0.in_ready), 0);

      // in_valid with in_ready low is ignored.
      set_in(0, 1'b1, 1'b1, 1'b0);
      tick(); tick();
      set_in(0, 1'b0, 1'b0, 1'b0);
      check("ignored valid fail_count", 32'(fc0), 0);
      check("ignored valid pass_count", 32'(pc0), 2);
      check("done held", 32'(done0), 1);

      // Single failure on the final sample.
      do_start(0);
      check("restart drops done", 32'(done0), 0);
      push_final(0, 1'b0, 16'd1, 1'b0, 1'b1);
      send(0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
      send(0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1);
      check("single fail pass", 32'(pass0), 0);

      // Restart from DONE with a failure recorded.
      do_start(0);
      check("restart fail_count", 32'(fc0), 0);
      check("restart first_fail", 32'({ffi0, ffe0, ffa0}), 0);
      push_final(0, 1'b1, 16'd0, 1'b0, 1'b0);
      send(0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0);
      send(0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0);
      check("restart pass", 32'(pass0), 1);

      // start mid-RUN is ignored.
      do_start(0);
      push_final(0, 1'b0, 16'd0, 1'b1, 1'b0);
      send(0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1);
      do_start(0);
      check("mid-run start busy", 32'(busy0), 1);
      check("mid-run start fail_count", 32'(fc0), 1);
      send(0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1);

      // rst mid-run discards results.
      do_start(0);
      send(0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort in_ready", 32'(sif0.in_ready), 0);
      check("abort busy", 32'(busy0), 0);
      check("abort counts", 32'({pc0, fc0}), 0);
      check("abort first_fail", 32'({ffi0, ffe0, ffa0}), 0);
      do_start(0);
      push_final(0, 1'b1, 16'd0, 1'b0, 1'b0);
      send(0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
      send(0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd0);
      check("after abort pass", 32'(pass0), 1);

      repeat (3) tick();
      check("u0 acc queue drained", 32'(aq0.size()), 0);
      check("u1 acc queue drained", 32'(aq1.size()), 0);
      check("u0 verdict queue drained", 32'(fq0.size()), 0);
      check("u1 verdict queue drained", 32'(fq1.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
